// File: rtl/md_pkg.sv
// Shared molecular-dynamics types: particle ids and force write-back records
// exchanged between the accumulators and the force cache.
package md_pkg;

  localparam int MD_DATA_WIDTH        = 32;
  localparam int MD_PARTICLE_ID_WIDTH = 8;
  localparam int MD_CELL_ID_WIDTH     = 3;
  localparam int MD_ID_WIDTH          = 3 * MD_CELL_ID_WIDTH + MD_PARTICLE_ID_WIDTH;

  localparam logic [MD_CELL_ID_WIDTH-1:0] CELL_1 = 3'd1;
  localparam logic [MD_CELL_ID_WIDTH-1:0] CELL_2 = 3'd2;
  localparam logic [MD_CELL_ID_WIDTH-1:0] CELL_3 = 3'd3;

  // cell_id is packed {z, y, x}
  typedef struct packed {
    logic [3*MD_CELL_ID_WIDTH-1:0]  cell_id;
    logic [MD_PARTICLE_ID_WIDTH-1:0] particle;
  } full_id_t;

  typedef struct packed {
    full_id_t                 id;
    logic [MD_DATA_WIDTH-1:0] fx;
    logic [MD_DATA_WIDTH-1:0] fy;
    logic [MD_DATA_WIDTH-1:0] fz;
  } wb_record_t;

  function automatic full_id_t pack_id(
    input logic [MD_CELL_ID_WIDTH-1:0]     cz,
    input logic [MD_CELL_ID_WIDTH-1:0]     cy,
    input logic [MD_CELL_ID_WIDTH-1:0]     cx,
    input logic [MD_PARTICLE_ID_WIDTH-1:0] p
  );
    full_id_t r;
    r.cell_id  = {cz, cy, cx};
    r.particle = p;
    return r;
  endfunction

endpackage

// File: rtl/wb_lane_fifo.sv
// Per-lane synchronous FIFO of write-back records. A push into a full FIFO is
// accepted only when the same cycle also pops; otherwise it is silently dropped.
module wb_lane_fifo
  import md_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  wb_record_t push_rec_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output wb_record_t head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_record_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign head_o  = mem[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; validity is defined purely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_rec_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/force_wb_collector.sv
// Collects one-cycle force pulses from the accumulator lanes into per-lane FIFOs
// and drains them round-robin, one record per cycle, over a valid/ready port.
module force_wb_collector
  import md_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 8,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int NUM_ACC           = 7,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic [NUM_ACC-1:0]                                        in_valid,
  input  logic [NUM_ACC*(3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH)-1:0]    in_id,
  input  logic [NUM_ACC*DATA_WIDTH-1:0]                             in_force_x,
  input  logic [NUM_ACC*DATA_WIDTH-1:0]                             in_force_y,
  input  logic [NUM_ACC*DATA_WIDTH-1:0]                             in_force_z,
  output logic                                                      out_valid,
  input  logic                                                      out_ready,
  output logic [((NUM_ACC > 1) ? $clog2(NUM_ACC) : 1)-1:0]          out_lane,
  output logic [3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH-1:0]              out_id,
  output logic [DATA_WIDTH-1:0]                                     out_force_x,
  output logic [DATA_WIDTH-1:0]                                     out_force_y,
  output logic [DATA_WIDTH-1:0]                                     out_force_z,
  output logic [NUM_ACC-1:0]                                        overflow,
  output logic                                                      idle
);

  localparam int ID_WIDTH = 3 * CELL_ID_WIDTH + PARTICLE_ID_WIDTH;
  localparam int LANE_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

  logic [NUM_ACC-1:0] lane_empty;
  logic [NUM_ACC-1:0] lane_full;
  logic [NUM_ACC-1:0] lane_pop;
  wb_record_t         lane_head [NUM_ACC];

  logic               load;
  logic               grant_valid;
  logic [LANE_W-1:0]  grant_lane;
  int                 scan_idx;
  logic [LANE_W-1:0]  scan_lane;

  wb_record_t         out_rec_q, out_rec_d;
  logic               out_valid_q, out_valid_d;
  logic [LANE_W-1:0]  out_lane_q, out_lane_d;
  logic [LANE_W-1:0]  rr_q, rr_d;
  logic [NUM_ACC-1:0] overflow_q, overflow_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ACC; gi++) begin : gen_lane
      wb_record_t lane_rec;

      assign lane_rec.id = full_id_t'(in_id[gi*ID_WIDTH +: ID_WIDTH]);
      assign lane_rec.fx = in_force_x[gi*DATA_WIDTH +: DATA_WIDTH];
      assign lane_rec.fy = in_force_y[gi*DATA_WIDTH +: DATA_WIDTH];
      assign lane_rec.fz = in_force_z[gi*DATA_WIDTH +: DATA_WIDTH];

      assign lane_pop[gi] = load & grant_valid & (grant_lane == LANE_W'(gi));

      wb_lane_fifo #(
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push_i     (in_valid[gi]),
        .push_rec_i (lane_rec),
        .pop_i      (lane_pop[gi]),
        .full_o     (lane_full[gi]),
        .empty_o    (lane_empty[gi]),
        .head_o     (lane_head[gi])
      );
    end
  endgenerate

  assign load = ~out_valid_q | out_ready;

  // Scan starts one past the last granted lane, so it is searched last next time.
  always_comb begin
    grant_valid = 1'b0;
    grant_lane  = '0;
    scan_idx    = 0;
    scan_lane   = '0;
    for (int k = 1; k <= NUM_ACC; k++) begin
      scan_idx = int'(rr_q) + k;
      if (scan_idx >= NUM_ACC) scan_idx = scan_idx - NUM_ACC;
      scan_lane = LANE_W'(scan_idx);
      if (!grant_valid && !lane_empty[scan_lane]) begin
        grant_valid = 1'b1;
        grant_lane  = scan_lane;
      end
    end
  end

  always_comb begin
    out_rec_d   = out_rec_q;
    out_valid_d = out_valid_q;
    out_lane_d  = out_lane_q;
    rr_d        = rr_q;
    if (load) begin
      if (grant_valid) begin
        out_rec_d   = lane_head[grant_lane];
        out_lane_d  = grant_lane;
        out_valid_d = 1'b1;
        rr_d        = grant_lane;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // A full lane that is popped this cycle still accepts its push, so no loss.
  assign overflow_d = overflow_q | (in_valid & lane_full & ~lane_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_rec_q   <= '0;
      out_valid_q <= 1'b0;
      out_lane_q  <= '0;
      rr_q        <= LANE_W'(NUM_ACC - 1);
      overflow_q  <= '0;
    end else begin
      out_rec_q   <= out_rec_d;
      out_valid_q <= out_valid_d;
      out_lane_q  <= out_lane_d;
      rr_q        <= rr_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_lane    = out_lane_q;
  assign out_id      = out_rec_q.id;
  assign out_force_x = out_rec_q.fx;
  assign out_force_y = out_rec_q.fy;
  assign out_force_z = out_rec_q.fz;
  assign overflow    = overflow_q;
  assign idle        = (&lane_empty) & ~out_valid_q;

endmodule

// File: tb/tb_force_wb_collector.sv
// Directed bench for force_wb_collector: per-cycle vector table plus hand-written
// sequences for the single-record, stall-free latency case and async reset.
module tb_force_wb_collector;

  localparam int NA  = 7;
  localparam int IDW = 17;
  localparam int DW  = 32;

  logic              clk;
  logic              rst;
  logic [NA-1:0]     in_valid;
  logic [NA*IDW-1:0] in_id;
  logic [NA*DW-1:0]  in_force_x;
  logic [NA*DW-1:0]  in_force_y;
  logic [NA*DW-1:0]  in_force_z;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_lane;
  logic [IDW-1:0]    out_id;
  logic [DW-1:0]     out_force_x;
  logic [DW-1:0]     out_force_y;
  logic [DW-1:0]     out_force_z;
  logic [NA-1:0]     overflow;
  logic              idle;

  int errors = 0;
  int checks = 0;

  force_wb_collector dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_id       (in_id),
    .in_force_x  (in_force_x),
    .in_force_y  (in_force_y),
    .in_force_z  (in_force_z),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_lane    (out_lane),
    .out_id      (out_id),
    .out_force_x (out_force_x),
    .out_force_y (out_force_y),
    .out_force_z (out_force_z),
    .overflow    (overflow),
    .idle        (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NA-1:0] iv;
    int            tag;
    logic          rdy;
    logic          ev;
    int            el;
    int            et;
    logic [NA-1:0] eov;
    logic          eidle;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic [NA-1:0] iv, int tag, logic rdy, logic ev, int el, int et,
                               logic [NA-1:0] eov, logic eidle);
    vec_t v;
    v.iv = iv; v.tag = tag; v.rdy = rdy; v.ev = ev; v.el = el; v.et = et; v.eov = eov; v.eidle = eidle;
    return v;
  endfunction

  function automatic logic [IDW-1:0] mk_id(int l, int t);
    logic [IDW-1:0] r;
    r = {3'(t), 3'(l), 3'(l + t), 8'(t * 8 + l)};
    return r;
  endfunction

  function automatic logic [DW-1:0] mk_fx(int l, int t);
    logic [DW-1:0] r;
    r = {16'h3F80, 8'(t), 8'(l)};
    return r;
  endfunction

  function automatic logic [DW-1:0] mk_fy(int l, int t);
    logic [DW-1:0] r;
    r = {16'hBF80, 8'(l), 8'(t)};
    return r;
  endfunction

  function automatic logic [DW-1:0] mk_fz(int l, int t);
    logic [DW-1:0] r;
    r = {8'(t), 8'(l), 16'h4120};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [NA-1:0] iv, input int tag, input logic rdy);
    for (int l = 0; l < NA; l++) begin
      in_id[l*IDW +: IDW]     = mk_id(l, tag);
      in_force_x[l*DW +: DW]  = mk_fx(l, tag);
      in_force_y[l*DW +: DW]  = mk_fy(l, tag);
      in_force_z[l*DW +: DW]  = mk_fz(l, tag);
    end
    in_valid  = iv;
    out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive('0, 0, 1'b0);
    repeat (3) step();
    rst = 1'b1;
  endtask

  logic [IDW-1:0] id1;

  initial begin
    rst = 1'b0;
    drive('0, 0, 1'b0);
    repeat (2) step();

    // Reset state while rst held low
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_lane", 64'(out_lane), 64'd0);
    chk("rst_id", 64'(out_id), 64'd0);
    chk("rst_fx", 64'(out_force_x), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    rst = 1'b1;
    step();

    // Single record on lane 3: visible one edge after capture, then idle again
    id1 = {3'd2, 3'd2, 3'd2, 8'd5};
    drive('0, 0, 1'b1);
    in_id[3*IDW +: IDW]    = id1;
    in_force_x[3*DW +: DW] = 32'h3F800000;
    in_force_y[3*DW +: DW] = 32'h40000000;
    in_force_z[3*DW +: DW] = 32'hC0400000;
    in_valid = 7'b0001000;
    step();
    chk("t1_valid0", 64'(out_valid), 64'd0);
    chk("t1_idle0", 64'(idle), 64'd0);
    in_valid = '0;
    step();
    chk("t1_valid1", 64'(out_valid), 64'd1);
    chk("t1_lane", 64'(out_lane), 64'd3);
    chk("t1_id", 64'(out_id), 64'(id1));
    chk("t1_fx", 64'(out_force_x), 64'h3F800000);
    chk("t1_fy", 64'(out_force_y), 64'h40000000);
    chk("t1_fz", 64'(out_force_z), 64'hC0400000);
    $display("t1: lane=%0d id=%0h fx=%0h", out_lane, out_id, out_force_x);
    step();
    chk("t1_valid2", 64'(out_valid), 64'd0);
    chk("t1_idle2", 64'(idle), 64'd1);

    do_reset();

    // All lanes at once: lanes 0..6 back to back
    vecs.push_back(mkv(7'h7F, 1, 1, 0, 0, 0, 7'h00, 0));
    for (int k = 0; k < NA; k++) vecs.push_back(mkv(7'h00, 0, 1, 1, k, 1, 7'h00, 0));
    vecs.push_back(mkv(7'h00, 0, 1, 0, 0, 0, 7'h00, 1));
    // Stall: lane 2 record held for 5 cycles, then lane 5
    vecs.push_back(mkv(7'h24, 2, 0, 0, 0, 0, 7'h00, 0));
    for (int k = 0; k < 6; k++) vecs.push_back(mkv(7'h00, 0, 0, 1, 2, 2, 7'h00, 0));
    vecs.push_back(mkv(7'h00, 0, 1, 1, 5, 2, 7'h00, 0));
    vecs.push_back(mkv(7'h00, 0, 1, 0, 0, 0, 7'h00, 1));
    // Overflow: lane 0 occupies the output, lane 1 gets 5 pushes into 4 slots
    vecs.push_back(mkv(7'h01, 10, 0, 0, 0, 0, 7'h00, 0));
    vecs.push_back(mkv(7'h02, 11, 0, 1, 0, 10, 7'h00, 0));
    vecs.push_back(mkv(7'h02, 12, 0, 1, 0, 10, 7'h00, 0));
    vecs.push_back(mkv(7'h02, 13, 0, 1, 0, 10, 7'h00, 0));
    vecs.push_back(mkv(7'h02, 14, 0, 1, 0, 10, 7'h00, 0));
    vecs.push_back(mkv(7'h02, 15, 0, 1, 0, 10, 7'h02, 0));
    for (int k = 11; k <= 14; k++) vecs.push_back(mkv(7'h00, 0, 1, 1, 1, k, 7'h02, 0));
    vecs.push_back(mkv(7'h00, 0, 1, 0, 0, 0, 7'h02, 1));
    // Fairness: lanes 0 and 2 alternate
    vecs.push_back(mkv(7'h05, 20, 0, 0, 0, 0, 7'h02, 0));
    vecs.push_back(mkv(7'h05, 21, 0, 1, 2, 20, 7'h02, 0));
    vecs.push_back(mkv(7'h05, 22, 0, 1, 2, 20, 7'h02, 0));
    vecs.push_back(mkv(7'h00, 0, 1, 1, 0, 20, 7'h02, 0));
    vecs.push_back(mkv(7'h00, 0, 1, 1, 2, 21, 7'h02, 0));
    vecs.push_back(mkv(7'h00, 0, 1, 1, 0, 21, 7'h02, 0));
    vecs.push_back(mkv(7'h00, 0, 1, 1, 2, 22, 7'h02, 0));
    vecs.push_back(mkv(7'h00, 0, 1, 1, 0, 22, 7'h02, 0));
    vecs.push_back(mkv(7'h00, 0, 1, 0, 0, 0, 7'h02, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].tag, vecs[i].rdy);
      step();
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_lane", i), 64'(out_lane), 64'(vecs[i].el));
        chk($sformatf("v%0d_id", i), 64'(out_id), 64'(mk_id(vecs[i].el, vecs[i].et)));
        chk($sformatf("v%0d_fx", i), 64'(out_force_x), 64'(mk_fx(vecs[i].el, vecs[i].et)));
        chk($sformatf("v%0d_fy", i), 64'(out_force_y), 64'(mk_fy(vecs[i].el, vecs[i].et)));
        chk($sformatf("v%0d_fz", i), 64'(out_force_z), 64'(mk_fz(vecs[i].el, vecs[i].et)));
      end
      chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].eov));
      chk($sformatf("v%0d_idle", i), 64'(idle), 64'(vecs[i].eidle));
      $display("vec %0d: in_valid=%b ready=%b -> valid=%b lane=%0d id=%0h ovf=%b idle=%b",
               i, vecs[i].iv, vecs[i].rdy, out_valid, out_lane, out_id, overflow, idle);
    end

    // Async reset mid-burst with 3 entries buffered (1 in output, 2 in FIFOs)
    drive(7'h38, 30, 1'b0);
    step();
    drive('0, 0, 1'b0);
    step();
    chk("t6_valid_pre", 64'(out_valid), 64'd1);
    chk("t6_lane_pre", 64'(out_lane), 64'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid_rst", 64'(out_valid), 64'd0);
    chk("t6_idle_rst", 64'(idle), 64'd1);
    chk("t6_ovf_rst", 64'(overflow), 64'd0);
    chk("t6_lane_rst", 64'(out_lane), 64'd0);
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t6_valid_post%0d", k), 64'(out_valid), 64'd0);
      chk($sformatf("t6_idle_post%0d", k), 64'(idle), 64'd1);
    end
    $display("t6: after reset valid=%b idle=%b ovf=%b", out_valid, idle, overflow);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
